// File: rtl/spi_flash_cmd_engine.sv
// spi_flash_cmd_engine
//
// SPI flash master for the channel-programming sequencer. Command words are
// held in a 128x32 write buffer (WBUF). A write-type command shifts
// flash_wr_nBits+1 bits out of consecutive WBUF words, MSB first. A bitstream
// load shifts the READ command in WBUF[0], waits MISO_DLY cycles for the
// pad/synchroniser pipeline, then streams BITSTREAM_BITS flash bits onto
// `bitstream`, one per clk.
//
// Parameters:
//   BITSTREAM_BITS  number of data bits streamed after the READ command
//   MISO_DLY        cycles from the last READ bit on MOSI to the first valid MISO sample
//
// Ports:
//   clk, reset_n                 system clock, async active-low reset
//   store_flash_command          write flash_command into WBUF[wbuf_address]
//   wbuf_address, flash_command  WBUF write address / data
//   flash_wr_nBits               bits to send minus 1 for a write-type command
//   send_write_command           level request, acked by end_write_command
//   read_bitstream               level request, acked by end_bitstream
//   bitstream                    registered serial bitstream output
//   spi_cs_n, spi_mosi, spi_miso, spi_clk_en   flash pins (SCK = gated ~clk)
//   bitstream_crc                CRC-32 of the last streamed bitstream
//
// Optional feature: define BITSTREAM_CRC_EN to compute a CRC-32
// (poly 0x04C11DB7, init all ones, MSB first, no final XOR) over the streamed
// bits. Without it bitstream_crc is tied to zero.

module spi_flash_cmd_engine #(
    parameter logic [31:0] BITSTREAM_BITS = 32'd28_734_368,
    parameter int unsigned MISO_DLY       = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        store_flash_command,
    input  logic [6:0]  wbuf_address,
    input  logic [31:0] flash_command,
    input  logic [11:0] flash_wr_nBits,
    input  logic        send_write_command,
    input  logic        read_bitstream,
    output logic        end_write_command,
    output logic        end_bitstream,
    output logic        bitstream,
    output logic        spi_cs_n,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        spi_clk_en,
    output logic [31:0] bitstream_crc
);

    // Wide enough to hold MISO_DLY-1.
    localparam int unsigned WAIT_W = (MISO_DLY < 2) ? 1 : $clog2(MISO_DLY);

    typedef enum logic [2:0] {
        StIdle,
        StWrShift,
        StRdCmd,
        StRdWait,
        StRdStream,
        StAckWr,
        StAckRd
    } state_t;

    state_t            state_q;
    logic [11:0]       bit_cnt_q;
    logic [6:0]        word_ptr_q;
    logic [4:0]        bit_idx_q;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic [31:0]       stream_cnt_q;

    logic [31:0] wbuf [128];

    logic [4:0] idx_nxt;
    logic [6:0] ptr_nxt;
    logic       shift_bit;

    // WBUF is plain storage: no reset, writable in any state.
    always_ff @(posedge clk) begin
        if (store_flash_command) begin
            wbuf[wbuf_address] <= flash_command;
        end
    end

    // Bit index wraps 0 -> 31 naturally; the word pointer steps on that wrap
    // so long commands run across consecutive words.
    always_comb begin
        idx_nxt   = bit_idx_q - 5'd1;
        ptr_nxt   = (bit_idx_q == 5'd0) ? word_ptr_q + 7'd1 : word_ptr_q;
        shift_bit = wbuf[ptr_nxt][idx_nxt];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= StIdle;
            bit_cnt_q         <= '0;
            word_ptr_q        <= '0;
            bit_idx_q         <= '0;
            wait_cnt_q        <= '0;
            stream_cnt_q      <= '0;
            spi_cs_n          <= 1'b1;
            spi_mosi          <= 1'b0;
            spi_clk_en        <= 1'b0;
            bitstream         <= 1'b0;
            end_write_command <= 1'b0;
            end_bitstream     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // Write has priority over read when both are requested.
                    if (send_write_command) begin
                        state_q    <= StWrShift;
                        bit_cnt_q  <= flash_wr_nBits;
                        word_ptr_q <= '0;
                        bit_idx_q  <= 5'd31;
                        spi_cs_n   <= 1'b0;
                        spi_clk_en <= 1'b1;
                        spi_mosi   <= wbuf[0][31];
                    end else if (read_bitstream) begin
                        state_q    <= StRdCmd;
                        word_ptr_q <= '0;
                        bit_idx_q  <= 5'd31;
                        spi_cs_n   <= 1'b0;
                        spi_clk_en <= 1'b1;
                        spi_mosi   <= wbuf[0][31];
                    end
                end

                // Outputs always show the bit selected by the counters; the
                // next bit is fetched one cycle ahead.
                StWrShift: begin
                    if (bit_cnt_q == 12'd0) begin
                        state_q           <= StAckWr;
                        spi_cs_n          <= 1'b1;
                        spi_clk_en        <= 1'b0;
                        spi_mosi          <= 1'b0;
                        end_write_command <= 1'b1;
                    end else begin
                        bit_cnt_q  <= bit_cnt_q - 12'd1;
                        bit_idx_q  <= idx_nxt;
                        word_ptr_q <= ptr_nxt;
                        spi_mosi   <= shift_bit;
                    end
                end

                StRdCmd: begin
                    if (bit_idx_q == 5'd0) begin
                        spi_mosi <= 1'b0;
                        if (MISO_DLY == 0) begin
                            state_q      <= StRdStream;
                            stream_cnt_q <= BITSTREAM_BITS - 32'd1;
                        end else begin
                            state_q    <= StRdWait;
                            wait_cnt_q <= WAIT_W'(MISO_DLY - 1);
                        end
                    end else begin
                        bit_idx_q <= idx_nxt;
                        spi_mosi  <= shift_bit;
                    end
                end

                StRdWait: begin
                    if (wait_cnt_q == '0) begin
                        state_q      <= StRdStream;
                        stream_cnt_q <= BITSTREAM_BITS - 32'd1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 1'b1;
                    end
                end

                StRdStream: begin
                    bitstream <= spi_miso;
                    if (stream_cnt_q == 32'd0) begin
                        state_q       <= StAckRd;
                        spi_cs_n      <= 1'b1;
                        spi_clk_en    <= 1'b0;
                        end_bitstream <= 1'b1;
                    end else begin
                        stream_cnt_q <= stream_cnt_q - 32'd1;
                    end
                end

                // 4-phase handshake: hold the ack until the request is seen low.
                StAckWr: begin
                    if (!send_write_command) begin
                        end_write_command <= 1'b0;
                        state_q           <= StIdle;
                    end
                end

                StAckRd: begin
                    bitstream <= 1'b1;
                    if (!read_bitstream) begin
                        end_bitstream <= 1'b0;
                        state_q       <= StIdle;
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef BITSTREAM_CRC_EN
    localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;

    logic [31:0] crc_q;
    logic [31:0] crc_next;
    logic        rd_start;
    logic        stream_last;

    always_comb begin
        crc_next    = {crc_q[30:0], 1'b0} ^ ((crc_q[31] ^ spi_miso) ? CRC_POLY : 32'd0);
        rd_start    = (state_q == StIdle) && !send_write_command && read_bitstream;
        stream_last = (state_q == StRdStream) && (stream_cnt_q == 32'd0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc_q         <= '1;
            bitstream_crc <= '0;
        end else begin
            if (rd_start) begin
                crc_q         <= '1;
                bitstream_crc <= '0;
            end else if (state_q == StRdStream) begin
                crc_q <= crc_next;
                // Include the final bit, which is sampled on this same edge.
                if (stream_last) begin
                    bitstream_crc <= crc_next;
                end
            end
        end
    end
`else
    assign bitstream_crc = 32'd0;
`endif

endmodule

// File: tb/tb_spi_flash_cmd_engine.sv
module tb_spi_flash_cmd_engine;

    localparam logic [31:0] BITS = 32'd64;
    localparam int unsigned DLY  = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        store_flash_command;
    logic [6:0]  wbuf_address;
    logic [31:0] flash_command;
    logic [11:0] flash_wr_nBits;
    logic        send_write_command;
    logic        read_bitstream;
    logic        end_write_command;
    logic        end_bitstream;
    logic        bitstream;
    logic        spi_cs_n;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_clk_en;
    logic [31:0] bitstream_crc;

    int checks = 0;
    int errors = 0;

    spi_flash_cmd_engine #(
        .BITSTREAM_BITS (BITS),
        .MISO_DLY       (DLY)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .store_flash_command (store_flash_command),
        .wbuf_address        (wbuf_address),
        .flash_command       (flash_command),
        .flash_wr_nBits      (flash_wr_nBits),
        .send_write_command  (send_write_command),
        .read_bitstream      (read_bitstream),
        .end_write_command   (end_write_command),
        .end_bitstream       (end_bitstream),
        .bitstream           (bitstream),
        .spi_cs_n            (spi_cs_n),
        .spi_mosi            (spi_mosi),
        .spi_miso            (spi_miso),
        .spi_clk_en          (spi_clk_en),
        .bitstream_crc       (bitstream_crc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [6:0] a, input logic [31:0] d);
        store_flash_command = 1'b1;
        wbuf_address        = a;
        flash_command       = d;
        tick();
        store_flash_command = 1'b0;
    endtask

    function automatic logic [31:0] crc_ref(input logic [63:0] d);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFF_FFFF;
        for (int i = 63; i >= 0; i--) begin
            fb = c[31] ^ d[i];
            c  = {c[30:0], 1'b0} ^ (fb ? 32'h04C1_1DB7 : 32'd0);
        end
        return c;
    endfunction

    // Expected MOSI bits are taken from bits[63] downwards. Caller raises send.
    task automatic write_body(input logic [63:0] bits, input int nb, input bit drop_early);
        int w;
        w = 0;
        flash_wr_nBits = 12'(nb);
        while (spi_cs_n && w < 4) begin
            tick();
            w++;
        end
        check("wr_cs_start", {31'd0, spi_cs_n}, 32'd0);
        for (int k = 0; k <= nb; k++) begin
            check("wr_cs_n", {31'd0, spi_cs_n}, 32'd0);
            check("wr_clk_en", {31'd0, spi_clk_en}, 32'd1);
            check("wr_mosi", {31'd0, spi_mosi}, {31'd0, bits[63-k]});
            check("wr_ack_early", {31'd0, end_write_command}, 32'd0);
            if (drop_early && k == 0) send_write_command = 1'b0;
            tick();
        end
        check("wr_cs_end", {31'd0, spi_cs_n}, 32'd1);
        check("wr_clk_en_end", {31'd0, spi_clk_en}, 32'd0);
        check("wr_ack", {31'd0, end_write_command}, 32'd1);
        if (!drop_early) begin
            tick();
            check("wr_ack_hold", {31'd0, end_write_command}, 32'd1);
            send_write_command = 1'b0;
        end
        tick();
        check("wr_ack_drop", {31'd0, end_write_command}, 32'd0);
    endtask

    // k counts cycles since cs_n fell: 0..31 command, 32..33 wait,
    // 34..97 MISO sampled, bitstream valid 35..98, ACK_RD from 98.
    task automatic read_body(input logic [31:0] cmd, input logic [63:0] data, input int abort_k);
        int w;
        w = 0;
        while (spi_cs_n && w < 4) begin
            tick();
            w++;
        end
        check("rd_cs_start", {31'd0, spi_cs_n}, 32'd0);
        for (int k = 0; k < 32; k++) begin
            check("rd_cs_n", {31'd0, spi_cs_n}, 32'd0);
            check("rd_clk_en", {31'd0, spi_clk_en}, 32'd1);
            check("rd_mosi", {31'd0, spi_mosi}, {31'd0, cmd[31-k]});
            tick();
        end
        for (int k = 32; k <= 98; k++) begin
            if (k == abort_k) begin
                reset_n = 1'b0;
                #1;
                check("rst_cs_n", {31'd0, spi_cs_n}, 32'd1);
                check("rst_clk_en", {31'd0, spi_clk_en}, 32'd0);
                check("rst_end_bs", {31'd0, end_bitstream}, 32'd0);
                check("rst_end_wr", {31'd0, end_write_command}, 32'd0);
                check("rst_bitstream", {31'd0, bitstream}, 32'd0);
                return;
            end
            if (k < 34) check("rd_wait_mosi", {31'd0, spi_mosi}, 32'd0);
            if (k >= 34 && k <= 97) spi_miso = data[63-(k-34)];
            else spi_miso = 1'b0;
            if (k >= 35) check("rd_bitstream", {31'd0, bitstream}, {31'd0, data[63-(k-35)]});
            if (k <= 97) begin
                check("rd_cs_low", {31'd0, spi_cs_n}, 32'd0);
                check("rd_end_bs_low", {31'd0, end_bitstream}, 32'd0);
            end else begin
                check("rd_cs_high", {31'd0, spi_cs_n}, 32'd1);
                check("rd_clk_en_off", {31'd0, spi_clk_en}, 32'd0);
                check("rd_end_bs", {31'd0, end_bitstream}, 32'd1);
`ifdef BITSTREAM_CRC_EN
                check("rd_crc", bitstream_crc, crc_ref(data));
`else
                check("rd_crc_off", bitstream_crc, 32'd0);
`endif
            end
            tick();
        end
        check("rd_bs_idle", {31'd0, bitstream}, 32'd1);
        check("rd_end_bs_hold", {31'd0, end_bitstream}, 32'd1);
        read_bitstream = 1'b0;
        tick();
        check("rd_end_bs_drop", {31'd0, end_bitstream}, 32'd0);
        check("rd_bs_after", {31'd0, bitstream}, 32'd1);
    endtask

    initial begin
        reset_n             = 1'b0;
        store_flash_command = 1'b0;
        wbuf_address        = '0;
        flash_command       = '0;
        flash_wr_nBits      = '0;
        send_write_command  = 1'b0;
        read_bitstream      = 1'b0;
        spi_miso            = 1'b0;
        #1;
        tick();
        tick();
        check("reset_cs_n", {31'd0, spi_cs_n}, 32'd1);
        check("reset_mosi", {31'd0, spi_mosi}, 32'd0);
        check("reset_clk_en", {31'd0, spi_clk_en}, 32'd0);
        check("reset_bitstream", {31'd0, bitstream}, 32'd0);
        check("reset_end_wr", {31'd0, end_write_command}, 32'd0);
        check("reset_end_bs", {31'd0, end_bitstream}, 32'd0);
        check("reset_crc", bitstream_crc, 32'd0);
        reset_n = 1'b1;
        tick();

        // Write-enable: 8 bits of 0x06.
        store(7'd0, 32'h0600_0000);
        send_write_command = 1'b1;
        write_body({32'h0600_0000, 32'h0}, 7, 1'b0);

        // Extended-address: 16 bits 0xC501.
        store(7'd0, 32'hC501_0000);
        send_write_command = 1'b1;
        write_body({32'hC501_0000, 32'h0}, 15, 1'b0);

        // Multi-word: 40 bits across words 0 and 1.
        store(7'd0, 32'hAAAA_AAAA);
        store(7'd1, 32'h5555_5555);
        send_write_command = 1'b1;
        write_body({32'hAAAA_AAAA, 32'h5555_5555}, 39, 1'b0);

        // Request dropped mid-transaction: ack pulses for one cycle.
        store(7'd0, 32'h0600_0000);
        send_write_command = 1'b1;
        write_body({32'h0600_0000, 32'h0}, 7, 1'b1);

        // Bitstream read.
        store(7'd0, 32'h0301_0000);
        read_bitstream = 1'b1;
        read_body(32'h0301_0000, 64'hDEAD_BEEF_0123_4567, -1);

        // Simultaneous requests: write first, read after its handshake.
        send_write_command = 1'b1;
        read_bitstream     = 1'b1;
        write_body({32'h0301_0000, 32'h0}, 7, 1'b0);
        check("simul_end_bs_idle", {31'd0, end_bitstream}, 32'd0);
        read_body(32'h0301_0000, 64'h0123_4567_89AB_CDEF, -1);

        // Reset at stream bit 20, then a full read from the start.
        read_bitstream = 1'b1;
        read_body(32'h0301_0000, 64'hDEAD_BEEF_0123_4567, 54);
        read_bitstream = 1'b0;
        spi_miso       = 1'b0;
        tick();
        check("rst_hold_cs_n", {31'd0, spi_cs_n}, 32'd1);
        reset_n = 1'b1;
        tick();
        read_bitstream = 1'b1;
        read_body(32'h0301_0000, 64'hDEAD_BEEF_0123_4567, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_flash_cmd_engine.md
Name: spi_flash_cmd_engine

Overview:
- SPI flash master directly downstream of the channel-programming sequencer.
- Holds command words in a 128x32 write buffer (WBUF) and shifts stored commands out to the configuration flash.
- For bitstream loads it issues the stored READ command, then streams BITSTREAM_BITS flash bits out one per clk on `bitstream` for the channel FPGAs.
- Owns the flash pins (chip select, MOSI, MISO sampling, SCK enable) while a transaction runs.

Parameters:
- BITSTREAM_BITS, 32'd28_734_368: number of data bits streamed after the READ command.
- MISO_DLY, 2: clk cycles between the last READ address bit leaving MOSI and the first valid MISO sample (pad plus synchroniser latency).

Ports:
- clk  in  1  system clock; SPI SCK is the externally gated inverse of clk.
- reset_n  in  1  asynchronous, active-low reset.
- store_flash_command  in  1  write flash_command into WBUF[wbuf_address].
- wbuf_address  in  7  WBUF word index.
- flash_command  in  32  command word; MSB is shifted first.
- flash_wr_nBits  in  12  number of bits to send minus 1.
- send_write_command  in  1  level request: send a write-type command.
- read_bitstream  in  1  level request: READ from WBUF[0], then stream the bitstream.
- end_write_command  out  1  level acknowledge for send_write_command.
- end_bitstream  out  1  level acknowledge for read_bitstream.
- bitstream  out  1  serial bitstream bit, registered.
- spi_cs_n  out  1  flash chip select.
- spi_mosi  out  1  flash data in.
- spi_miso  in  1  flash data out.
- spi_clk_en  out  1  SCK gate enable.
- bitstream_crc  out  32  CRC of the last streamed bitstream (optional feature).

Behaviour:
- Reset values:
  - spi_cs_n=1, spi_mosi=0, spi_clk_en=0, bitstream=0.
  - end_write_command=0, end_bitstream=0, bitstream_crc=0.
  - State=IDLE, all counters 0.
  - WBUF contents are not reset.
- WBUF writes:
  - Synchronous, one cycle, accepted in any state.
  - A write to the word currently being shifted is undefined; the sequencer never does this.
- States:
  - IDLE
  - WR_SHIFT
  - RD_CMD
  - RD_WAIT
  - RD_STREAM
  - ACK_WR
  - ACK_RD
- IDLE:
  - send_write_command=1 → WR_SHIFT. Load bit counter with flash_wr_nBits; word pointer=0, bit index=31.
  - Else read_bitstream=1 → RD_CMD.
  - If both are high in the same cycle, write has priority.
- WR_SHIFT:
  - spi_cs_n=0 and spi_clk_en=1 for exactly flash_wr_nBits+1 cycles.
  - spi_mosi = WBUF[ptr][idx], MSB first.
  - On idx wrap 0→31, ptr increments, so up to 4096 bits span consecutive words.
  - After the last bit: cs_n=1, clk_en=0 on the next cycle → ACK_WR.
- ACK_WR:
  - end_write_command=1.
  - Held until send_write_command is sampled 0, then deasserts → IDLE (4-phase handshake).
- RD_CMD:
  - cs_n=0, clk_en=1; shift all 32 bits of WBUF[0] MSB first → RD_WAIT.
- RD_WAIT:
  - cs_n=0, clk_en=1 for MISO_DLY cycles; MOSI=0 → RD_STREAM.
- RD_STREAM:
  - Each cycle bitstream<=spi_miso.
  - 32-bit down-counter loaded with BITSTREAM_BITS-1.
  - At counter 0: cs_n=1, clk_en=0 next cycle → ACK_RD.
  - Exactly BITSTREAM_BITS bits are delivered. bitstream returns to 1 after the stream.
- ACK_RD:
  - end_bitstream=1 until read_bitstream is sampled 0 → IDLE.
- Request dropped mid-transaction:
  - The transaction still completes.
  - The ACK state is entered, sees the request already low, and holds the acknowledge high for exactly 1 cycle.
- Async reset mid-transaction:
  - Immediate cs_n=1 and clk_en=0; the flash sees an aborted command.
- spi_cs_n high time between transactions is at least 2 cycles: the ACK cycle plus the IDLE cycle.

Optional Feature:
- BITSTREAM_CRC_EN defined:
  - CRC-32 (poly 0x04C11DB7, init 0xFFFF_FFFF, MSB-first, no final XOR) computed over every bit delivered in RD_STREAM.
  - Latched into bitstream_crc when ACK_RD is entered.
  - Register is cleared on entering RD_CMD.
- BITSTREAM_CRC_EN undefined:
  - bitstream_crc tied to 32'd0; no CRC logic.

Test Plan:
- Write-enable command:
  - Stimulus: store 0x0600_0000 at addr 0, nBits=7, raise send.
  - Required: cs_n low for exactly 8 cycles; MOSI=00000110; end_write_command high until send drops, then low within 1 cycle.
- Extended-address command:
  - Stimulus: store 0xC501_0000, nBits=15.
  - Required: 16 bits 0xC501 on MOSI; clk_en high exactly 16 cycles.
- Multi-word write:
  - Stimulus: words 0/1 = 0xAAAA_AAAA/0x5555_5555, nBits=39.
  - Required: 32 alternating bits 1010…, then 8 bits 01010101; cs_n deasserts after bit 40.
- Bitstream read:
  - Stimulus: BITSTREAM_BITS=64, MISO_DLY=2, WBUF[0]=0x0301_0000, MISO model returns 0xDEAD_BEEF_0123_4567.
  - Required: 32 command bits on MOSI; bitstream carries those 64 bits in order; end_bitstream asserts; with BITSTREAM_CRC_EN, bitstream_crc matches the reference model.
- Simultaneous requests:
  - Stimulus: send and read rise in the same cycle.
  - Required: write executes first; after its handshake completes, the read starts.
- Reset mid-stream:
  - Stimulus: reset_n=0 at stream bit 20.
  - Required: cs_n=1, clk_en=0, both acks 0 asynchronously; a new read after release delivers all 64 bits from the start.
